// File: rtl/axi_sram_pkg.sv
// Shared AXI encodings and FSM state types for the AXI4 SRAM responder.
// WRAP bursts are enabled by defining AXI_SRAM_WRAP_BURST_EN.
package axi_sram_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_sram_storage.sv
// Word array with a byte-enable write port and a combinational read port.
// Reads see pre-write contents; writes land at the clock edge.
module axi_sram_storage #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [IW-1:0]           waddr_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [IW-1:0]           raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wstrb_i[b]) begin
          mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/axi4_sram_responder.sv
// AXI4 slave fronting an on-chip SRAM; one outstanding burst per direction.
// Define AXI_SRAM_WRAP_BURST_EN to accept WRAP bursts (else they return SLVERR).
module axi4_sram_responder
  import axi_sram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    ID_WIDTH    = 4,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0800_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_s_axi_aw_valid,
  output logic                    io_s_axi_aw_ready,
  input  logic [ID_WIDTH-1:0]     io_s_axi_aw_bits_id,
  input  logic [ADDR_WIDTH-1:0]   io_s_axi_aw_bits_addr,
  input  logic [7:0]              io_s_axi_aw_bits_len,
  input  logic [2:0]              io_s_axi_aw_bits_size,
  input  logic [1:0]              io_s_axi_aw_bits_burst,
  input  logic                    io_s_axi_w_valid,
  output logic                    io_s_axi_w_ready,
  input  logic [DATA_WIDTH-1:0]   io_s_axi_w_bits_data,
  input  logic [DATA_WIDTH/8-1:0] io_s_axi_w_bits_strb,
  input  logic                    io_s_axi_w_bits_last,
  output logic                    io_s_axi_b_valid,
  input  logic                    io_s_axi_b_ready,
  output logic [ID_WIDTH-1:0]     io_s_axi_b_bits_id,
  output logic [1:0]              io_s_axi_b_bits_resp,
  input  logic                    io_s_axi_ar_valid,
  output logic                    io_s_axi_ar_ready,
  input  logic [ID_WIDTH-1:0]     io_s_axi_ar_bits_id,
  input  logic [ADDR_WIDTH-1:0]   io_s_axi_ar_bits_addr,
  input  logic [7:0]              io_s_axi_ar_bits_len,
  input  logic [2:0]              io_s_axi_ar_bits_size,
  input  logic [1:0]              io_s_axi_ar_bits_burst,
  output logic                    io_s_axi_r_valid,
  input  logic                    io_s_axi_r_ready,
  output logic [ID_WIDTH-1:0]     io_s_axi_r_bits_id,
  output logic [DATA_WIDTH-1:0]   io_s_axi_r_bits_data,
  output logic [1:0]              io_s_axi_r_bits_resp,
  output logic                    io_s_axi_r_bits_last
);

  localparam int AW = ADDR_WIDTH;
  localparam int LB = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int unsigned MEMB = DEPTH_WORDS * (DATA_WIDTH / 8);
`ifdef AXI_SRAM_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  function automatic logic beat_err(
    input logic [AW-1:0] a,
    input logic [2:0]    sz,
    input logic [1:0]    bt,
    input logic [7:0]    ln
  );
    logic [AW-1:0] off;
    logic          e;
    off = a - BASE_ADDR;
    e = ({1'b0, off} >= (AW+1)'(MEMB)) || (sz > 3'(LB));
    case (bt)
      BURST_FIXED, BURST_INCR: ;
      BURST_WRAP: e = e || !WRAP_EN || !wrap_len_ok(ln);
      default:    e = 1'b1;
    endcase
    return e;
  endfunction

  // WRAP keeps the upper bits of the aligned window and wraps the low ones
  function automatic logic [AW-1:0] next_addr(
    input logic [AW-1:0] a,
    input logic [2:0]    sz,
    input logic [1:0]    bt,
    input logic [7:0]    ln
  );
    logic [AW-1:0] step;
    logic [AW-1:0] mask;
    logic [AW-1:0] n;
    step = AW'(1) << sz;
    mask = ((AW'(ln) + AW'(1)) << sz) - AW'(1);
    case (bt)
      BURST_INCR: n = a + step;
      BURST_WRAP: n = (a & ~mask) | ((a + step) & mask);
      default:    n = a;
    endcase
    return n;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
    return IW'((a - BASE_ADDR) >> LB);
  endfunction

  logic rdy_q;

  wr_state_e             w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [AW-1:0]         w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_err_q, w_err_d;
  logic [1:0]            b_resp_q, b_resp_d;

  rd_state_e             r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [AW-1:0]         r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic                  r_last_q, r_last_d;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  w_beat_err, mem_we;
  logic [AW-1:0]         rd_addr;
  logic [2:0]            rd_size;
  logic [1:0]            rd_burst;
  logic [7:0]            rd_len;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] rd_data;

  assign io_s_axi_aw_ready = rdy_q && (w_state_q == W_IDLE);
  assign io_s_axi_w_ready  = (w_state_q == W_DATA);
  assign io_s_axi_b_valid  = (w_state_q == W_RESP);
  assign io_s_axi_b_bits_id   = w_id_q;
  assign io_s_axi_b_bits_resp = b_resp_q;

  assign io_s_axi_ar_ready = rdy_q && (r_state_q == R_IDLE);
  assign io_s_axi_r_valid  = (r_state_q == R_DATA);
  assign io_s_axi_r_bits_id   = r_id_q;
  assign io_s_axi_r_bits_data = r_data_q;
  assign io_s_axi_r_bits_resp = r_resp_q;
  assign io_s_axi_r_bits_last = r_last_q;

  assign aw_hs = io_s_axi_aw_valid && io_s_axi_aw_ready;
  assign w_hs  = io_s_axi_w_valid  && io_s_axi_w_ready;
  assign b_hs  = io_s_axi_b_valid  && io_s_axi_b_ready;
  assign ar_hs = io_s_axi_ar_valid && io_s_axi_ar_ready;
  assign r_hs  = io_s_axi_r_valid  && io_s_axi_r_ready;

  assign w_beat_err = beat_err(w_addr_q, w_size_q, w_burst_q, w_len_q);
  assign mem_we     = w_hs && !w_beat_err;

  // The read port looks at the beat to be presented after the next edge
  always_comb begin
    rd_addr  = next_addr(r_addr_q, r_size_q, r_burst_q, r_len_q);
    rd_size  = r_size_q;
    rd_burst = r_burst_q;
    rd_len   = r_len_q;
    if (r_state_q == R_IDLE) begin
      rd_addr  = io_s_axi_ar_bits_addr;
      rd_size  = io_s_axi_ar_bits_size;
      rd_burst = io_s_axi_ar_bits_burst;
      rd_len   = io_s_axi_ar_bits_len;
    end
  end

  assign rd_err = beat_err(rd_addr, rd_size, rd_burst, rd_len);

  axi_sram_storage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_storage (
    .clk_i   (clock),
    .we_i    (mem_we),
    .waddr_i (word_idx(w_addr_q)),
    .wstrb_i (io_s_axi_w_bits_strb),
    .wdata_i (io_s_axi_w_bits_data),
    .raddr_i (word_idx(rd_addr)),
    .rdata_o (rd_data)
  );

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    b_resp_d  = b_resp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_state_d = W_DATA;
          w_id_d    = io_s_axi_aw_bits_id;
          w_addr_d  = io_s_axi_aw_bits_addr;
          w_len_d   = io_s_axi_aw_bits_len;
          w_size_d  = io_s_axi_aw_bits_size;
          w_burst_d = io_s_axi_aw_bits_burst;
          w_cnt_d   = 8'd0;
          w_err_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q, w_len_q);
          w_cnt_d  = w_cnt_q + 8'd1;
          w_err_d  = w_err_q || w_beat_err;
          if (io_s_axi_w_bits_last || (w_cnt_q == w_len_q)) begin
            w_state_d = W_RESP;
            b_resp_d  = (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          r_id_d    = io_s_axi_ar_bits_id;
          r_addr_d  = io_s_axi_ar_bits_addr;
          r_len_d   = io_s_axi_ar_bits_len;
          r_size_d  = io_s_axi_ar_bits_size;
          r_burst_d = io_s_axi_ar_bits_burst;
          r_cnt_d   = 8'd0;
          r_data_d  = rd_err ? '0 : rd_data;
          r_resp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
          r_last_d  = (io_s_axi_ar_bits_len == 8'd0);
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (r_last_q) begin
            r_state_d = R_IDLE;
            r_last_d  = 1'b0;
          end else begin
            r_addr_d = rd_addr;
            r_cnt_d  = r_cnt_q + 8'd1;
            r_data_d = rd_err ? '0 : rd_data;
            r_resp_d = rd_err ? RESP_SLVERR : RESP_OKAY;
            r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdy_q     <= 1'b0;
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      b_resp_q  <= '0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      rdy_q     <= 1'b1;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      b_resp_q  <= b_resp_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
    end
  end

endmodule

// File: doc/axi4_sram_responder.md
AXI4_SRAM_RESPONDER -- requirements
Module: axi4_sram_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus bits (32 or 128).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address bits.
REQ-003 SHALL have parameter ID_WIDTH, default 4, AXI ID bits.
REQ-004 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in DATA_WIDTH words (power of 2).
REQ-005 SHALL have parameter BASE_ADDR, default 32'h0800_0000, byte address of word 0.
REQ-006 SHALL have port clock, input, 1, sole clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have AW group io_s_axi_aw_{valid in 1, ready out 1, bits_id in ID_WIDTH, bits_addr in ADDR_WIDTH, bits_len in 8, bits_size in 3, bits_burst in 2}: write address.
REQ-009 SHALL have W group io_s_axi_w_{valid in 1, ready out 1, bits_data in DATA_WIDTH, bits_strb in DATA_WIDTH/8, bits_last in 1}: write data.
REQ-010 SHALL have B group io_s_axi_b_{valid out 1, ready in 1, bits_id out ID_WIDTH, bits_resp out 2}: write response.
REQ-011 SHALL have AR group io_s_axi_ar_{valid, ready, bits_id, bits_addr, bits_len, bits_size, bits_burst}, widths and directions as AW: read address.
REQ-012 SHALL have R group io_s_axi_r_{valid out 1, ready in 1, bits_id out ID_WIDTH, bits_data out DATA_WIDTH, bits_resp out 2, bits_last out 1}: read data.

Function
REQ-013 SHALL run independent write FSM (W_IDLE, W_DATA, W_RESP) and read FSM (R_IDLE, R_DATA); one outstanding transaction per direction.
REQ-014 SHALL assert aw_ready only in W_IDLE; AW handshake -> W_DATA, latching id, addr, len, size, burst, beat count 0.
REQ-015 SHALL assert w_ready only in W_DATA; W arriving before the AW handshake is held off.
REQ-016 SHALL, per W beat, write byte lanes where strb=1 into word (addr-BASE_ADDR)>>log2(DATA_WIDTH/8) at end of that cycle.
REQ-017 SHALL advance beat address: INCR += 1<<size; FIXED unchanged; WRAP per REQ-032.
REQ-018 SHALL leave W_DATA on handshake with w_last=1 or beat count==len, whichever first -> W_RESP; b_valid high next cycle.
REQ-019 SHALL hold b_valid, b_bits_id, b_bits_resp stable until b_ready; handshake -> W_IDLE, aw_ready high next cycle.
REQ-020 SHALL assert ar_ready only in R_IDLE; AR handshake -> R_DATA, r_valid high next cycle with beat 0.
REQ-021 SHALL present each R beat registered; hold data/resp/last/id stable while r_valid && !r_ready; r_last=1 on beat len; handshake on last beat -> R_IDLE.
REQ-022 SHALL return OKAY (2'b00); SLVERR (2'b10) for a beat whose address is outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*DATA_WIDTH/8) or whose size > log2(DATA_WIDTH/8); erroneous beats do not write; read data 0.
REQ-023 SHALL report write response SLVERR if any beat of the burst erred.
REQ-024 SHALL, when read beat and write beat hit the same word in one cycle, return pre-write data.
REQ-025 SHALL wrap beat address modulo 2^ADDR_WIDTH without error beyond REQ-022.

Reset
REQ-026 SHALL, on reset assertion, immediately force both FSMs idle and drive aw_ready=0, w_ready=0, ar_ready=0, b_valid=0, r_valid=0, r_bits_last=0, ids/resp/data=0.
REQ-027 SHALL drive aw_ready=1 and ar_ready=1 on the first clock edge after reset deasserts.
REQ-028 SHALL abandon in-flight bursts on reset mid-operation with no response; storage contents not cleared.

Configuration
REQ-029 SHALL support WRAP bursts only when AXI_SRAM_WRAP_BURST_EN is defined.
REQ-030 SHALL, without the macro, answer burst==2'b10 with SLVERR on every beat, no writes, still accepting/producing len+1 beats.
REQ-031 SHALL treat burst==2'b11 as SLVERR in both builds.
REQ-032 SHALL, with the macro, wrap address within the aligned (len+1)<<size window; len not in {1,3,7,15} -> SLVERR.

Structure
REQ-033 SHALL place AXI resp and burst encodings and FSM state enums in package axi_sram_pkg.
REQ-034 SHALL instantiate one sub-module axi_sram_storage (byte-enable write port, read port) holding the array.

Verification
REQ-035 Single write 0xDEADBEEF @0x0800_0000 strb 0xF, then read -> b_resp OKAY, r_data 0xDEADBEEF, r_last 1.
REQ-036 Write 0x01020304 @0x0800_0004 strb 0x3 over 0xFFFFFFFF -> read 0xFFFF0304.
REQ-037 INCR len=3 size=2 write 1,2,3,4 @0x0800_0010, read back with r_ready toggling every cycle -> 1,2,3,4, r_last only on beat 3, data stable while stalled.
REQ-038 Read @0x2000_0000 -> one beat, r_resp 2'b10, r_data 0; write there -> b_resp 2'b10, storage unchanged.
REQ-039 WRAP len=3 size=2 @0x0800_0028 -> beats 0x28,0x2C,0x20,0x24 OKAY with macro; all SLVERR without.
REQ-040 Assert reset during beat 2 of INCR len=7 read -> r_valid 0 immediately, ar_ready 1 after release, earlier-written data intact.
